// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - output word stream between fifo_rd_stream and its consumer
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - pops a FWFT async-FIFO read port into a packetised valid/ready stream
module fifo_rd_stream #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DSIZE-1:0]    rdata,
  output logic                rinc,
  input  logic                en,
  input  logic                flush,
  fifo_rd_stream_if.master    m,
  output logic [15:0]         word_cnt
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [1:0]       occ;
  logic [DSIZE-1:0] word0;
  logic [DSIZE-1:0] word1;
  logic [BW-1:0]    beat;
  logic             armed;
  logic             xfer;

  // armed keeps rinc low until the first edge after reset release
  assign rinc      = armed & en & ~rempty & ~flush & (occ != 2'd2);
  assign xfer      = m.m_valid & m.m_ready & ~flush;
  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = word0;
  assign m.m_last  = m.m_valid & (beat == LAST_BEAT);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ      <= 2'd0;
      word0    <= '0;
      word1    <= '0;
      beat     <= '0;
      word_cnt <= 16'd0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        occ  <= 2'd0;
        beat <= '0;
      end else begin
        case ({rinc, xfer})
          2'b10: begin
            if (occ == 2'd0) word0 <= rdata;
            else             word1 <= rdata;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            word0 <= word1;
            occ   <= occ - 2'd1;
          end
          2'b11: begin
            // head leaves while the new word lands behind whatever remains
            if (occ == 2'd1) begin
              word0 <= rdata;
            end else begin
              word0 <= word1;
              word1 <= rdata;
            end
          end
          default: ;
        endcase
        if (xfer) begin
          beat     <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
          word_cnt <= word_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream (PKT_LEN=4)
module tb_fifo_rd_stream;

  logic        rclk;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        en;
  logic        flush;
  logic [15:0] word_cnt;

  fifo_rd_stream_if #(.DSIZE(8)) s_if ();

  fifo_rd_stream #(.DSIZE(8), .PKT_LEN(4)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .en       (en),
    .flush    (flush),
    .m        (s_if.master),
    .word_cnt (word_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  logic [7:0] q[$];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic void refresh();
    rempty = (q.size() == 0);
    rdata  = (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  // upstream FWFT FIFO model; tasks edit q at negedges, model republishes 1ns later
  initial begin
    logic p;
    q.delete();
    refresh();
    forever begin
      @(posedge rclk);
      p = rinc && !rempty;
      #1;
      if (p) begin
        void'(q.pop_front());
        pop_cnt++;
      end
      refresh();
      @(negedge rclk);
      #1;
      refresh();
    end
  end

  task automatic start_stream(input logic [7:0] base, input int n, input logic rdy);
    @(negedge rclk);
    rrst_n = 1'b0;
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
    en = 1'b1;
    flush = 1'b0;
    s_if.m_ready = rdy;
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    pop_cnt = 0;
  endtask

  task automatic test_reset();
    q.delete();
    q.push_back(8'h55);
    en = 1'b1;
    s_if.m_ready = 1'b1;
    repeat (3) @(negedge rclk);
    #2;
    checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL reset_rinc got=%b exp=0", rinc); end
    checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", s_if.m_valid); end
    checks++; if (s_if.m_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", s_if.m_last); end
    checks++; if (s_if.m_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", s_if.m_data); end
    checks++; if (word_cnt !== 16'h0000) begin failures++; $display("FAIL reset_word_cnt got=%h exp=0000", word_cnt); end
    rrst_n = 1'b1;
    #1;
    checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL release_rinc_before_edge got=%b exp=0", rinc); end
    @(negedge rclk);
    #1;
    checks++; if (rinc !== 1'b1) begin failures++; $display("FAIL release_rinc_after_edge got=%b exp=1", rinc); end
    @(negedge rclk);
    checks++;
    if ({s_if.m_valid, s_if.m_data} !== {1'b1, 8'h55}) begin
      failures++; $display("FAIL first_word got=%b/%h exp=1/55", s_if.m_valid, s_if.m_data);
    end
  endtask

  task automatic test_stream();
    int t = 0;
    start_stream(8'h00, 8, 1'b1);
    while (!s_if.m_valid && t < 10) begin @(negedge rclk); t++; end
    checks++; if (s_if.m_valid !== 1'b1) begin failures++; $display("FAIL stream_timeout got=%b exp=1", s_if.m_valid); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({s_if.m_valid, s_if.m_last, s_if.m_data} !== {1'b1, (i % 4 == 3), 8'(i)}) begin
        failures++;
        $display("FAIL stream_beat%0d got=%b/%b/%h exp=1/%b/%h", i, s_if.m_valid, s_if.m_last, s_if.m_data, (i % 4 == 3), 8'(i));
      end
      @(negedge rclk);
    end
    checks++; if (word_cnt !== 16'd8) begin failures++; $display("FAIL stream_word_cnt got=%0d exp=8", word_cnt); end
    checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", s_if.m_valid); end
  endtask

  task automatic test_stall();
    int got = 0;
    start_stream(8'hA0, 5, 1'b0);
    repeat (6) @(negedge rclk);
    checks++; if (pop_cnt !== 2) begin failures++; $display("FAIL stall_pops got=%0d exp=2", pop_cnt); end
    checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL stall_rinc got=%b exp=0", rinc); end
    checks++; if (q.size() !== 3) begin failures++; $display("FAIL stall_fifo_left got=%0d exp=3", q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({s_if.m_valid, s_if.m_data} !== {1'b1, 8'hA0}) begin
        failures++; $display("FAIL stall_hold%0d got=%b/%h exp=1/a0", i, s_if.m_valid, s_if.m_data);
      end
      @(negedge rclk);
    end
    s_if.m_ready = 1'b1;
    for (int t = 0; t < 20 && got < 5; t++) begin
      if (s_if.m_valid) begin
        checks++;
        if (s_if.m_data !== 8'hA0 + 8'(got)) begin
          failures++; $display("FAIL stall_drain%0d got=%h exp=%h", got, s_if.m_data, 8'hA0 + 8'(got));
        end
        got++;
      end
      @(negedge rclk);
    end
    checks++; if (got !== 5) begin failures++; $display("FAIL stall_count got=%0d exp=5", got); end
    checks++; if (word_cnt !== 16'd5) begin failures++; $display("FAIL stall_word_cnt got=%0d exp=5", word_cnt); end
  endtask

  task automatic test_backpressure();
    int got = 0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    start_stream(8'h10, 8, 1'b1);
    for (int t = 0; t < 40 && got < 8; t++) begin
      s_if.m_ready = (t % 2 == 0);
      #1;
      if (stalled) begin
        checks++;
        if ({s_if.m_valid, s_if.m_data} !== {1'b1, held}) begin
          failures++; $display("FAIL bp_stable t=%0d got=%b/%h exp=1/%h", t, s_if.m_valid, s_if.m_data, held);
        end
      end
      if (s_if.m_valid && s_if.m_ready) begin
        checks++;
        if (s_if.m_data !== 8'h10 + 8'(got)) begin
          failures++; $display("FAIL bp_word%0d got=%h exp=%h", got, s_if.m_data, 8'h10 + 8'(got));
        end
        got++;
      end
      stalled = s_if.m_valid && !s_if.m_ready;
      held = s_if.m_data;
      @(negedge rclk);
    end
    checks++; if (got !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got); end
    checks++; if (word_cnt !== 16'd8) begin failures++; $display("FAIL bp_word_cnt got=%0d exp=8", word_cnt); end
  endtask

  task automatic test_flush();
    int got = 0;
    start_stream(8'h20, 16, 1'b0);
    repeat (6) @(negedge rclk);
    s_if.m_ready = 1'b1;
    repeat (2) @(negedge rclk);
    s_if.m_ready = 1'b0;
    repeat (2) @(negedge rclk);
    checks++;
    if ({s_if.m_valid, s_if.m_last, s_if.m_data} !== {1'b1, 1'b0, 8'h22}) begin
      failures++; $display("FAIL flush_pre got=%b/%b/%h exp=1/0/22", s_if.m_valid, s_if.m_last, s_if.m_data);
    end
    checks++; if (word_cnt !== 16'd2) begin failures++; $display("FAIL flush_pre_cnt got=%0d exp=2", word_cnt); end
    flush = 1'b1;
    s_if.m_ready = 1'b1;
    #1;
    checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL flush_rinc got=%b exp=0", rinc); end
    @(negedge rclk);
    flush = 1'b0;
    #1;
    checks++; if (word_cnt !== 16'd2) begin failures++; $display("FAIL flush_cnt got=%0d exp=2", word_cnt); end
    checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", s_if.m_valid); end
    for (int t = 0; t < 20 && got < 4; t++) begin
      if (s_if.m_valid) begin
        checks++;
        if ({s_if.m_last, s_if.m_data} !== {(got == 3), 8'h24 + 8'(got)}) begin
          failures++;
          $display("FAIL flush_post%0d got=%b/%h exp=%b/%h", got, s_if.m_last, s_if.m_data, (got == 3), 8'h24 + 8'(got));
        end
        got++;
      end
      @(negedge rclk);
    end
    checks++; if (got !== 4) begin failures++; $display("FAIL flush_post_count got=%0d exp=4", got); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int got = 0;
    logic [7:0] head;
    start_stream(8'h30, 16, 1'b1);
    while (!s_if.m_valid && t < 10) begin @(negedge rclk); t++; end
    repeat (3) @(negedge rclk);
    #2;
    rrst_n = 1'b0;
    #1;
    checks++;
    if ({s_if.m_valid, s_if.m_last, s_if.m_data, rinc, word_cnt} !== 28'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b/%b/%h/%b/%h exp=0/0/00/0/0000", s_if.m_valid, s_if.m_last, s_if.m_data, rinc, word_cnt);
    end
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    head = (q.size() != 0) ? q[0] : 8'h00;
    rrst_n = 1'b1;
    for (int k = 0; k < 20 && got < 4; k++) begin
      if (s_if.m_valid) begin
        checks++;
        if ({s_if.m_last, s_if.m_data} !== {(got == 3), head + 8'(got)}) begin
          failures++;
          $display("FAIL midreset_word%0d got=%b/%h exp=%b/%h", got, s_if.m_last, s_if.m_data, (got == 3), head + 8'(got));
        end
        got++;
      end
      @(negedge rclk);
    end
    checks++; if (got !== 4) begin failures++; $display("FAIL midreset_count got=%0d exp=4", got); end
  endtask

  task automatic test_en_drain();
    start_stream(8'h40, 3, 1'b0);
    repeat (6) @(negedge rclk);
    en = 1'b0;
    s_if.m_ready = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({s_if.m_valid, s_if.m_data, rinc} !== {1'b1, 8'h40 + 8'(i), 1'b0}) begin
        failures++;
        $display("FAIL en_drain%0d got=%b/%h/%b exp=1/%h/0", i, s_if.m_valid, s_if.m_data, rinc, 8'h40 + 8'(i));
      end
      @(negedge rclk);
      #1;
    end
    checks++; if (s_if.m_valid !== 1'b0) begin failures++; $display("FAIL en_empty got=%b exp=0", s_if.m_valid); end
    checks++; if (pop_cnt !== 2) begin failures++; $display("FAIL en_pops got=%0d exp=2", pop_cnt); end
  endtask

  task automatic test_wrap();
    int xfers = 0;
    start_stream(8'h00, 0, 1'b1);
    for (int t = 0; t < 70000; t++) begin
      if (q.size() < 4) q.push_back(t[7:0]);
      if (xfers == 65535) begin
        checks++; if (word_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", word_cnt); end
      end
      if (xfers == 65536) begin
        checks++; if (word_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", word_cnt); end
      end
      if (xfers == 65540) break;
      if (s_if.m_valid && s_if.m_ready) xfers++;
      @(negedge rclk);
    end
    s_if.m_ready = 1'b0;
    en = 1'b0;
    checks++; if (xfers !== 65540) begin failures++; $display("FAIL wrap_timeout got=%0d exp=65540", xfers); end
    checks++; if (word_cnt !== 16'h0004) begin failures++; $display("FAIL wrap_final got=%h exp=0004", word_cnt); end
  endtask

  initial begin
    rrst_n = 1'b0;
    en = 1'b0;
    flush = 1'b0;
    s_if.m_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_en_drain();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DSIZE, default 8, data word width; SHALL match the upstream async FIFO DSIZE.
REQ-002 Parameter PKT_LEN, default 4, words per output packet; legal range 1..256.
REQ-003 rclk  input  1  sole clock; the read-side clock of the upstream async FIFO.
REQ-004 rrst_n  input  1  asynchronous, active-low reset.
REQ-005 rempty  input  1  upstream FIFO empty flag.
REQ-006 rdata  input  DSIZE  upstream FIFO head word; first-word-fall-through, valid whenever rempty=0.
REQ-007 rinc  output  1  pop request to upstream FIFO; a pop occurs on an rclk rising edge with rinc=1 and rempty=0.
REQ-008 en  input  1  fetch enable; 0 stops new pops while buffered words continue to drain.
REQ-009 flush  input  1  synchronous clear of buffered words and packet position.
REQ-010 m_valid  output  1  output word valid.
REQ-011 m_ready  input  1  downstream accept; a transfer occurs on a rising edge with m_valid=1 and m_ready=1.
REQ-012 m_data  output  DSIZE  output word.
REQ-013 m_last  output  1  marks the final word of each PKT_LEN-word packet.
REQ-014 word_cnt  output  16  count of completed output transfers, wraps modulo 2^16.

Function
REQ-015 The block SHALL hold a 2-entry internal buffer with occupancy occ in 0..2, read out in FIFO order.
REQ-016 rinc SHALL equal en & ~rempty & ~flush & (occ != 2), with occ taken from the register; rinc SHALL have no combinational path from m_ready.
REQ-017 A pop SHALL write rdata into the buffer tail on the same edge; the word SHALL appear on m_data with m_valid=1 on the next cycle (1-cycle latency).
REQ-018 m_valid SHALL equal (occ != 0); m_data SHALL be the buffer head.
REQ-019 While m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL hold stable.
REQ-020 Pop and transfer on the same edge SHALL leave occ unchanged; pop alone SHALL add 1; transfer alone SHALL subtract 1.
REQ-021 With rempty=0, en=1 and m_ready=1 held, the block SHALL sustain one transfer per cycle after the first-word latency.
REQ-022 Beat counter beat (width ceil(log2(PKT_LEN)), minimum 1 bit) SHALL increment on each transfer and wrap from PKT_LEN-1 to 0.
REQ-023 m_last SHALL equal m_valid & (beat == PKT_LEN-1); with PKT_LEN=1, m_last SHALL equal m_valid.
REQ-024 word_cnt SHALL increment by 1 on each transfer and wrap from 0xFFFF to 0x0000.
REQ-025 flush=1 SHALL, at the next edge, set occ=0 and beat=0 and discard buffered words; no pop SHALL occur in that cycle; word_cnt SHALL be unaffected.
REQ-026 A transfer presented in the same cycle as flush=1 SHALL NOT be counted; flush takes priority.
REQ-027 en=0 SHALL force rinc=0 and leave draining, m_last and word_cnt behaviour otherwise unchanged.
REQ-028 rempty rising while occ>0 SHALL NOT affect words already buffered.

Reset
REQ-029 rrst_n=0 SHALL asynchronously force occ=0, beat=0, word_cnt=0, m_valid=0, m_last=0 and rinc=0, and SHALL clear m_data to 0.
REQ-030 Reset assertion mid-packet SHALL discard buffered words; after release, the first transfer SHALL be beat 0.
REQ-031 rinc SHALL stay 0 until the first rclk edge after rrst_n deasserts.

Verification
REQ-032 FIFO preloaded with 0x00..0x07, en=1, m_ready=1, PKT_LEN=4 -> m_data 0x00..0x07 on 8 consecutive cycles, m_last on 0x03 and 0x07, word_cnt=8.
REQ-033 FIFO holds 0xA0..0xA4, m_ready=0 -> rinc pulses exactly twice, occ=2, m_data holds 0xA0; m_ready=1 -> 0xA0..0xA4 delivered in order with no loss.
REQ-034 m_ready toggling 1,0,1,0 with continuous data -> no duplicated or dropped words, and m_data stable during every stall cycle.
REQ-035 flush asserted with occ=2 after beat=2 -> next delivered word is the FIFO head at flush time, with beat=0 and no m_last until the 4th subsequent word.
REQ-036 rrst_n pulsed low for 3 cycles mid-stream -> all outputs 0 immediately, word_cnt=0, and delivery restarts cleanly from the FIFO head.
REQ-037 word_cnt preloaded near wrap by 65 540 transfers -> value reads 0x0004 after wrap.
